r_type_encoder_loader: RTL and testbench



---
 rtl/r_type_encoder_loader_pkg.sv | 65 ++++++
 rtl/r_type_encoder_loader_r_type_word_fifo.sv | 50 +++++
 rtl/r_type_encoder_loader.sv | 132 +++++++++++++
 tb/tb_r_type_encoder_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/r_type_encoder_loader_pkg.sv
// Shared R-type encoding constants, ALU control codes and the word encoder.
// Reused by the loader and by the decoder-side bench.
package r_type_encoder_loader_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    localparam logic [6:0] OPCODE_R = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0033;

    function automatic logic r_legal(input logic [4:0] alu);
        return alu <= ALU_AND;
    endfunction

    // Illegal codes become a NOP so later addresses stay put.
    function automatic logic [31:0] encode_r(
        input logic [4:0] alu,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rd
    );
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        f3 = F3_ADD_SUB;
        f7 = F7_BASE;
        ok = 1'b1;
        unique case (alu)
            ALU_ADD:  f3 = F3_ADD_SUB;
            ALU_SUB:  begin f3 = F3_ADD_SUB; f7 = F7_ALT; end
            ALU_SLL:  f3 = F3_SLL;
            ALU_SLT:  f3 = F3_SLT;
            ALU_SLTU: f3 = F3_SLTU;
            ALU_XOR:  f3 = F3_XOR;
            ALU_SRL:  f3 = F3_SRL_SRA;
            ALU_SRA:  begin f3 = F3_SRL_SRA; f7 = F7_ALT; end
            ALU_OR:   f3 = F3_OR;
            ALU_AND:  f3 = F3_AND;
            default:  ok = 1'b0;
        endcase
        return ok ? {f7, rs2, rs1, f3, rd, OPCODE_R} : NOP_WORD;
    endfunction

endpackage

// File: rtl/r_type_encoder_loader_r_type_word_fifo.sv
// Two-entry 32-bit synchronous FIFO holding encoded words
// waiting for the instruction-memory write port.
module r_type_word_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] din,
    input  logic        pop,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        wptr;
    logic        rptr;
    logic        do_push;
    logic        do_pop;

    assign full    = count == 2'd2;
    assign empty   = count == 2'd0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/r_type_encoder_loader.sv
// Accepts R-type requests, encodes them and streams the words
// sequentially into instruction memory through a 2-entry buffer.
module r_type_encoder_loader
    import r_type_encoder_loader_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] num_instr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_alu_control,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err_illegal,
    output logic [15:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

    state_t      state;
    state_t      state_n;
    logic [15:0] target;
    logic [15:0] accepted;
    logic [31:0] addr;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [1:0]  count;
    logic [31:0] head;
    logic [31:0] word;
    logic        go;

    assign go        = (state == S_IDLE) && start;
    assign req_ready = (state == S_LOAD) && !full && (accepted < target);
    assign push      = req_valid && req_ready;
    assign pop       = !empty && imem_ready;
    assign word      = encode_r(req_alu_control, req_rs1, req_rs2, req_rd);

    assign imem_we    = !empty;
    assign imem_wdata = head;
    assign imem_addr  = addr;
    assign busy       = (state == S_LOAD) || (state == S_DRAIN);
    assign done       = state == S_DONE;

    r_type_word_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Leave LOAD on the last accept and DRAIN on the last write,
    // so done follows the final write by one cycle.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (num_instr == 16'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (push && (accepted + 16'd1 == target)) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty || (pop && count == 2'd1)) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            target      <= '0;
            accepted    <= '0;
            addr        <= BASE_ADDR;
            wr_count    <= '0;
            err_illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (go) begin
                target      <= num_instr;
                accepted    <= '0;
                addr        <= BASE_ADDR;
                wr_count    <= '0;
                err_illegal <= 1'b0;
            end else begin
                if (push) begin
                    accepted <= accepted + 16'd1;
                    if (!r_legal(req_alu_control)) begin
                        err_illegal <= 1'b1;
                    end
                end
                if (pop) begin
                    addr     <= (addr == LAST_ADDR) ? BASE_ADDR : addr + 32'd4;
                    wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_r_type_encoder_loader.sv
// Directed bench for r_type_encoder_loader (DEPTH=4 to reach the wrap).
module tb_r_type_encoder_loader;
    import r_type_encoder_loader_pkg::*;

    typedef struct {
        logic [4:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_instr = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_alu_control = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [4:0]  req_rd = '0;
    logic        imem_we;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err_illegal;
    logic [15:0] wr_count;

    r_type_encoder_loader #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .num_instr       (num_instr),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_alu_control (req_alu_control),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .req_rd          (req_rd),
        .imem_we         (imem_we),
        .imem_ready      (imem_ready),
        .imem_addr       (imem_addr),
        .imem_wdata      (imem_wdata),
        .busy            (busy),
        .done            (done),
        .err_illegal     (err_illegal),
        .wr_count        (wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          ac[$];
    logic        pstall = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;
    int          unstable = 0;
    vec_t        vt[11];
    vec_t        rq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only move #1 after posedge, so negedge sees what the next edge samples.
    always @(negedge clk) begin
        if (imem_we && imem_ready) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            wc.push_back(cyc);
        end
        if (req_valid && req_ready) ac.push_back(cyc);
        if (pstall && imem_we && (imem_addr != pa || imem_wdata != pd))
            unstable <= unstable + 1;
        pstall <= imem_we && !imem_ready;
        pa     <= imem_addr;
        pd     <= imem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 0);
        chk({tag, " imem_we"}, 32'(imem_we), 0);
        chk({tag, " imem_addr"}, imem_addr, 0);
        chk({tag, " imem_wdata"}, imem_wdata, 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " err_illegal"}, 32'(err_illegal), 0);
        chk({tag, " wr_count"}, 32'(wr_count), 0);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        ac.delete();
    endtask

    task automatic kick(input int n);
        clear_log();
        start = 1'b1;
        num_instr = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int t = 0;
        req_valid = 1'b1;
        req_alu_control = v.alu;
        req_rs1 = v.rs1;
        req_rs2 = v.rs2;
        req_rd = v.rd;
        @(negedge clk);
        while (!req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("req_ready timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_all();
        foreach (rq[i]) send(rq[i]);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        @(negedge clk);
        while (!done && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk({name, " done"}, 32'(done), 1);
        @(posedge clk); #1;
        chk({name, " done pulse"}, 32'(done), 0);
    endtask

    task automatic chk_writes(input string name, input int base);
        chk({name, " nwrites"}, 32'(wd.size()), 32'(rq.size()));
        for (int i = 0; i < rq.size() && i < wd.size(); i++) begin
            chk($sformatf("%s word%0d", name, i), wd[i], rq[i].word);
            chk($sformatf("%s addr%0d", name, i), wa[i], 32'(((base + i) % 4) * 4));
        end
    endtask

    initial begin
        vt[0]  = '{ALU_ADD,  5'd1,  5'd2,  5'd3,  32'h002081B3};
        vt[1]  = '{ALU_SUB,  5'd6,  5'd7,  5'd5,  32'h407302B3};
        vt[2]  = '{ALU_SRA,  5'd11, 5'd12, 5'd10, 32'h40C5D533};
        vt[3]  = '{ALU_AND,  5'd2,  5'd3,  5'd1,  32'h003170B3};
        vt[4]  = '{ALU_SLL,  5'd5,  5'd6,  5'd4,  32'h00629233};
        vt[5]  = '{ALU_SLT,  5'd8,  5'd9,  5'd7,  32'h009423B3};
        vt[6]  = '{ALU_SLTU, 5'd2,  5'd3,  5'd1,  32'h003130B3};
        vt[7]  = '{ALU_XOR,  5'd30, 5'd29, 5'd31, 32'h01DF4FB3};
        vt[8]  = '{ALU_SRL,  5'd3,  5'd4,  5'd2,  32'h0041D133};
        vt[9]  = '{ALU_OR,   5'd1,  5'd1,  5'd0,  32'h0010E033};
        vt[10] = '{5'h1F,    5'd9,  5'd9,  5'd9,  32'h00000033};

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        rq.delete();
        rq.push_back(vt[0]);
        kick(1);
        chk("start busy", 32'(busy), 1);
        chk("start req_ready", 32'(req_ready), 1);
        send_all();
        wait_done("add");
        chk_writes("add", 0);
        chk("add latency", 32'(wc[0] - ac[0]), 1);
        chk("add wr_count", 32'(wr_count), 1);

        rq.delete();
        rq.push_back(vt[1]);
        rq.push_back(vt[2]);
        rq.push_back(vt[3]);
        kick(3);
        send_all();
        wait_done("b2b");
        chk_writes("b2b", 0);
        if (wc.size() == 3) chk("b2b no bubbles", 32'(wc[2] - wc[0]), 2);
        else chk("b2b write log", 32'(wc.size()), 3);

        rq.delete();
        rq.push_back(vt[0]);
        rq.push_back(vt[1]);
        rq.push_back(vt[4]);
        rq.push_back(vt[7]);
        imem_ready = 1'b0;
        unstable = 0;
        kick(4);
        fork
            send_all();
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("bp accepts while stalled", 32'(ac.size()), 2);
                chk("bp req_ready low", 32'(req_ready), 0);
                chk("bp we held", 32'(imem_we), 1);
                imem_ready = 1'b1;
            end
        join
        wait_done("bp");
        chk_writes("bp", 0);
        chk("bp stable while stalled", 32'(unstable), 0);
        chk("bp wr_count", 32'(wr_count), 4);

        rq.delete();
        rq.push_back(vt[5]);
        rq.push_back(vt[10]);
        rq.push_back(vt[6]);
        kick(3);
        send_all();
        wait_done("illegal");
        chk_writes("illegal", 0);
        chk("illegal sticky", 32'(err_illegal), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("illegal still sticky", 32'(err_illegal), 1);

        rq.delete();
        foreach (vt[i]) rq.push_back(vt[i]);
        kick(11);
        chk("err cleared by start", 32'(err_illegal), 0);
        send_all();
        wait_done("table");
        chk_writes("table", 0);
        chk("table wr_count", 32'(wr_count), 11);
        chk("table err", 32'(err_illegal), 1);

        rq.delete();
        kick(0);
        wait_done("zero");
        chk("zero nwrites", 32'(wd.size()), 0);
        chk("zero wr_count", 32'(wr_count), 0);

        rq.delete();
        imem_ready = 1'b0;
        kick(4);
        send(vt[0]);
        send(vt[1]);
        rst_n = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        chk_reset("midreset");
        imem_ready = 1'b1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset no writes", 32'(wd.size()), 0);
        chk("midreset we", 32'(imem_we), 0);
        chk("midreset busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
